// File: rtl/add_stream_stage_pkg.sv
// Shared types and constants for the add_stream_stage block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package add_stream_stage_pkg;

  localparam int ADD_N_DEFAULT  = 32;
  localparam int ADD_FIFO_DEPTH = 2;

  // Result record at the default width; wider/narrower instances build
  // the same layout locally and hand it to the FIFO as a type parameter.
  typedef struct packed {
    logic [ADD_N_DEFAULT-1:0] sum;
    logic                     cout;
    logic                     overflow;
    logic                     zero;
    logic                     neg;
  } add_result_t;

endpackage

// File: rtl/CSA.sv
// Combinational carry-skip adder, 4-bit groups with a skip mux per group.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module CSA #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o,
  output logic         c_msb_o
);

  // Ripple inside each group; a fully propagating group forwards its carry-in directly.
  always_comb begin
    logic       c;
    logic [4:0] r;
    logic [3:0] pg;
    c     = cin_i;
    r     = '0;
    pg    = '0;
    sum_o = '0;
    for (int k = 0; k < N / 4; k++) begin
      r  = {1'b0, a_i[4*k +: 4]} + {1'b0, b_i[4*k +: 4]} + {4'b0, c};
      pg = a_i[4*k +: 4] ^ b_i[4*k +: 4];
      sum_o[4*k +: 4] = r[3:0];
      c  = (&pg) ? c : r[4];
    end
    cout_o = c;
  end

  // Carry into the MSB is recovered from the MSB sum bit and its propagate term.
  assign c_msb_o = sum_o[N-1] ^ a_i[N-1] ^ b_i[N-1];

endmodule

// File: rtl/result_fifo2.sv
// Two-entry synchronous FIFO carrying one result record per entry.
// Latency: push at edge k -> visible at head after edge k (if empty).
// Backpressure: caller must not push when full unless popping in the same cycle.
module result_fifo2
  import add_stream_stage_pkg::*;
#(
  parameter type T = add_result_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  T           wdata_i,
  output T           rdata_o,
  output logic [1:0] count_o
);

  T           mem_q [ADD_FIFO_DEPTH];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointers; reset clears data so the head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ADD_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/add_stream_stage.sv
// Registered valid/ready wrapper around CSA with a flagged 2-entry result FIFO.
// Latency: accept at edge k -> result at head after edge k+1; 1 result/cycle sustained.
// Backpressure: in_ready = ~s1_valid | fifo_can_accept (combinational from out_ready); 3 pairs in flight at full stall.
module add_stream_stage
  import add_stream_stage_pkg::*;
#(
  parameter int N     = ADD_N_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_cout,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             out_neg,
  output logic [CNT_W-1:0] op_count
);

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         zero;
    logic         neg;
  } res_t;

  logic             s1_valid_q, s1_valid_d;
  logic [N-1:0]     s1_a_q, s1_b_q;
  logic [N-1:0]     sum;
  logic             cout, c_msb;
  res_t             res, head;
  logic [1:0]       fifo_count;
  logic             fifo_can_accept, push, pop, accept;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  CSA #(.N(N)) u_csa (
    .a_i    (s1_a_q),
    .b_i    (s1_b_q),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (cout),
    .c_msb_o(c_msb)
  );

  // Status flags are derived from the adder output in the same cycle as the sum.
  always_comb begin
    res.sum      = sum;
    res.cout     = cout;
    res.overflow = c_msb ^ cout;
    res.zero     = (sum == '0);
    res.neg      = sum[N-1];
  end

  // A full FIFO still takes a push when its head leaves this cycle.
  assign out_valid       = (fifo_count != 2'd0);
  assign pop             = out_valid & out_ready;
  assign fifo_can_accept = (fifo_count < 2'(ADD_FIFO_DEPTH)) | pop;
  assign push            = s1_valid_q & fifo_can_accept;
  assign in_ready        = ~rst & (~s1_valid_q | fifo_can_accept);
  assign accept          = in_valid & in_ready;
  assign s1_valid_d      = accept | (s1_valid_q & ~push);
  assign op_count_d      = pop ? op_count_q + CNT_W'(1) : op_count_q;

  // Operand register: reloads on accept, may refill in the same cycle it pushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_a_q <= in_a;
        s1_b_q <= in_b;
      end
    end
  end

  // Completed-operation counter, wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (rst) op_count_q <= '0;
    else     op_count_q <= op_count_d;
  end

  result_fifo2 #(.T(res_t)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(res),
    .rdata_o(head),
    .count_o(fifo_count)
  );

  assign out_sum      = head.sum;
  assign out_cout     = head.cout;
  assign out_overflow = head.overflow;
  assign out_zero     = head.zero;
  assign out_neg      = head.neg;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_add_stream_stage.sv
// Bench for add_stream_stage: directed vector table, handshake corner sequences and random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_add_stream_stage;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst, in_valid, out_ready;
  logic [N-1:0]  in_a, in_b;
  logic          in_ready, out_valid, out_cout, out_overflow, out_zero, out_neg;
  logic [N-1:0]  out_sum;
  logic [15:0]   op_count;
  logic          d4_in_ready, d4_out_valid, d4_cout, d4_ovf, d4_zero, d4_neg;
  logic [N-1:0]  d4_sum;
  logic [3:0]    d4_op_count;

  always #5 clk = ~clk;

  add_stream_stage #(.N(N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_overflow(out_overflow),
    .out_zero(out_zero), .out_neg(out_neg), .op_count(op_count)
  );

  add_stream_stage #(.N(N), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d4_in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(d4_out_valid), .out_ready(out_ready),
    .out_sum(d4_sum), .out_cout(d4_cout), .out_overflow(d4_ovf),
    .out_zero(d4_zero), .out_neg(d4_neg), .op_count(d4_op_count)
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    res_t        exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  res_t        mq[$];
  bit          s1v;
  res_t        s1r;
  int unsigned pops;
  bit          acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: 33-bit arithmetic; signed overflow from operand/result sign rule.
  function automatic res_t ref_add(input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    logic [32:0] s;
    s      = {1'b0, a} + {1'b0, b};
    r.sum  = s[31:0];
    r.cout = s[32];
    r.ovf  = (a[31] == b[31]) && (s[31] != a[31]);
    r.zero = (s[31:0] == 32'd0);
    r.neg  = s[31];
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                              input logic c, input logic o, input logic z, input logic n);
    vec_t v;
    v.a   = a;
    v.b   = b;
    v.exp = '{s, c, o, z, n};
    return v;
  endfunction

  function automatic res_t head_now();
    return '{out_sum, out_cout, out_overflow, out_zero, out_neg};
  endfunction

  // One clock: compare DUT against the model, then advance the model across the edge.
  task automatic tick();
    bit can_acc, pop_m, push_m, acc_m;
    #1;
    can_acc = (mq.size() < 2) || (mq.size() != 0 && out_ready);
    pop_m   = (mq.size() != 0) && out_ready;
    push_m  = s1v && can_acc;
    acc_m   = !rst && in_valid && (!s1v || can_acc);
    chk("in_ready", in_ready, !rst && (!s1v || can_acc));
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) chk("head", head_now(), mq[0]);
    chk("op_count", op_count, pops[15:0]);
    chk("op_count4", d4_op_count, pops[3:0]);
    acc = acc_m;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      s1v  = 1'b0;
      pops = 0;
    end else begin
      if (pop_m) begin
        void'(mq.pop_front());
        pops++;
      end
      if (push_m) mq.push_back(s1r);
      if (acc_m) begin
        s1v = 1'b1;
        s1r = ref_add(in_a, in_b);
      end else if (push_m) begin
        s1v = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[9];
    logic [31:0] got[$];
    int          n;

    vt[0] = mk(32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 0, 0, 0, 0);
    vt[1] = mk(32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1, 0, 1);
    vt[2] = mk(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1, 0);
    vt[3] = mk(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, 1, 1, 0);
    vt[4] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0, 0, 1);
    vt[5] = mk(32'h0000_000F, 32'h0000_0001, 32'h0000_0010, 0, 0, 0, 0);
    vt[6] = mk(32'h0FFF_FFFF, 32'h0000_0001, 32'h1000_0000, 0, 0, 0, 0);
    vt[7] = mk(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0, 1, 0);
    vt[8] = mk(32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1, 1, 0, 0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    mq.delete(); s1v = 1'b0; pops = 0;
    @(posedge clk); #1;
    chk("rst_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors: single add each, check flags then pop.
    foreach (vt[i]) begin
      in_valid = 1'b1; in_a = vt[i].a; in_b = vt[i].b; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_res", i), head_now(), vt[i].exp);
      chk($sformatf("vec%0d_cnt_before", i), op_count, i);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("vec%0d_cnt_after", i), op_count, i + 1);
    end

    // Back-pressure: four pairs against a stalled consumer.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_a = N'(i); in_b = N'(i);
      if (i == 4) begin
        #1;
        chk("bp_ready_drop", in_ready, 0);
      end
      tick();
      if (i < 4) chk($sformatf("bp_accept%0d", i), acc, 1);
    end
    out_ready = 1'b1;
    n = 0;
    while (got.size() < 4 && n < 20) begin
      if (out_valid) got.push_back(out_sum);
      tick();
      if (acc) in_valid = 1'b0;
      n++;
    end
    chk("bp_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("bp_res%0d", i), got[i], 2 * (i + 1));

    // Full-rate streaming starting from a full FIFO.
    in_valid = 1'b0; n = 0;
    repeat (4) tick();
    out_ready = 1'b0;
    for (int k = 0; k < 10 && n < 3; k++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      tick();
      if (acc) n++;
    end
    chk("fr_filled", n, 3);
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      #1;
      chk("fr_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();

    // Reset with three results in flight.
    out_ready = 1'b0; n = 0;
    for (int k = 0; k < 10 && n < 3; k++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      tick();
      if (acc) n++;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (5) begin
      tick();
      chk("post_rst_no_stale", out_valid, 0);
    end

    // Counter wrap: 17 pops on the 4-bit counter instance.
    n = 0;
    for (int k = 0; k < 40 && n < 17; k++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      tick();
      if (acc) n++;
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("wrap_cnt4", d4_op_count, 1);
    chk("wrap_cnt16", op_count, 17);

    // Random traffic with random stalls and corner operands.
    for (int k = 0; k < 300; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       begin in_a = 32'h7FFF_FFFF; in_b = $urandom_range(0, 3); end
        1:       begin in_a = 32'hFFFF_FFFF; in_b = $urandom_range(0, 3); end
        2:       begin in_a = $urandom; in_b = ~in_a + 32'(($urandom_range(0, 1))); end
        default: begin in_a = $urandom; in_b = $urandom; end
      endcase
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
